fb_pixel_writer: RTL and testbench

Sink end of the shape-iterator pixel handshake. Consumes the `x`/`y`/`drawing` stream produced by a shape iterator (square, line, and others) and throttles it through `oe`. Clips each pixel against the framebuffer, converts it to a linear address, buffers it, and issues framebuffer writes whenever the memory arbiter grants a slot. Sits between the render iterators and the framebuffer write-port arbiter. Signals `flush_done` once every pixel of a shape has been committed.

---
 rtl/render_pkg.sv | 12 +
 rtl/pix_fifo.sv | 51 +++++
 rtl/fb_pixel_writer.sv | 125 ++++++++++++
 tb/tb_fb_pixel_writer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared render-pipeline constants and the pixel writer FSM encoding.
package render_pkg;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int ADDRW     = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wr_state_e;
endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO with first-word-fall-through head and an occupancy count.
module pix_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTRW:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wptr;
  logic [PTRW-1:0]  rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTRW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel sink: clips iterator pixels, converts to linear addresses, buffers them
// and writes them to the framebuffer port as the arbiter grants slots.
module fb_pixel_writer #(
  parameter int CORDW     = 10,
  parameter int COLRW     = 4,
  parameter int FB_WIDTH  = render_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = render_pkg::FB_HEIGHT,
  parameter int ADDRW     = render_pkg::ADDRW,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CORDW-1:0]      x,
  input  logic [CORDW-1:0]      y,
  input  logic [COLRW-1:0]      colr,
  input  logic                  drawing,
  output logic                  oe,
  input  logic                  shape_done,
  output logic [ADDRW-1:0]      fb_addr,
  output logic [COLRW-1:0]      fb_colr,
  output logic                  fb_we,
  input  logic                  fb_grant,
  output logic                  busy,
  output logic                  flush_done,
  output logic [7:0]            clip_cnt,
  output render_pkg::wr_state_e dbg_state
);
  import render_pkg::*;

  localparam int PTRW = $clog2(DEPTH);
  localparam int FW   = ADDRW + COLRW;

  // Handshakes: the iterator pixel moves on any cycle with drawing && oe;
  // a framebuffer write completes on any cycle with fb_we && fb_grant, and
  // fb_addr/fb_colr hold steady until then.

  wr_state_e        state;
  logic             accept;
  logic             s1_valid;
  logic             s1_clip;
  logic [ADDRW-1:0] s1_addr;
  logic [COLRW-1:0] s1_colr;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [PTRW:0]    count;
  logic [FW-1:0]    head;
  logic [PTRW+1:0]  occ;
  logic             clip_inc;
  logic             drain_done;

  // Occupancy includes the S1 slot so a pixel accepted now always fits.
  assign occ    = {1'b0, count} + {{(PTRW+1){1'b0}}, s1_valid};
  assign oe     = rst_n && (occ < (PTRW+2)'(DEPTH));
  assign accept = drawing && oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_clip  <= 1'b0;
      s1_addr  <= '0;
      s1_colr  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_clip <= (int'(x) >= FB_WIDTH) || (int'(y) >= FB_HEIGHT);
        s1_addr <= ADDRW'(y) * ADDRW'(FB_WIDTH) + ADDRW'(x);
        s1_colr <= colr;
      end
    end
  end

  assign push     = s1_valid && !s1_clip;
  assign clip_inc = s1_valid && s1_clip;
  assign pop      = fb_we && fb_grant;

  pix_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({s1_addr, s1_colr}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign fb_we   = !empty;
  assign fb_addr = empty ? '0 : head[FW-1:COLRW];
  assign fb_colr = empty ? '0 : head[COLRW-1:0];

  assign drain_done = !s1_valid && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clip_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE:    if (accept || shape_done) state <= shape_done ? DRAIN : RUN;
        RUN:     if (shape_done) state <= DRAIN;
        DRAIN:   if (drain_done) state <= IDLE;
        default: state <= IDLE;
      endcase
      // A new shape restarts the count; its first pixel is counted later from S1.
      if (state == IDLE && (accept || shape_done))
        clip_cnt <= clip_inc ? 8'd1 : 8'd0;
      else if (clip_inc && clip_cnt != 8'hFF)
        clip_cnt <= clip_cnt + 8'd1;
    end
  end

  assign busy       = (state != IDLE);
  assign flush_done = (state == DRAIN) && drain_done;
  assign dbg_state  = state;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed and randomized bench for fb_pixel_writer against a queue-based write model.
`timescale 1ns/1ps
module tb_fb_pixel_writer;
  import render_pkg::*;

  localparam int CORDW = 10;
  localparam int COLRW = 4;
  localparam int W     = 320;
  localparam int H     = 240;
  localparam int AW    = 17;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CORDW-1:0] x = '0;
  logic [CORDW-1:0] y = '0;
  logic [COLRW-1:0] colr = '0;
  logic             drawing = 1'b0;
  logic             oe;
  logic             shape_done = 1'b0;
  logic [AW-1:0]    fb_addr;
  logic [COLRW-1:0] fb_colr;
  logic             fb_we;
  logic             fb_grant = 1'b0;
  logic             busy;
  logic             flush_done;
  logic [7:0]       clip_cnt;
  wr_state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  int clip_exp = 0;
  int flush_cnt = 0;
  int grant_mode = 1;
  logic [AW+COLRW-1:0] exp_q[$];

  fb_pixel_writer #(
    .CORDW(CORDW), .COLRW(COLRW), .FB_WIDTH(W), .FB_HEIGHT(H), .ADDRW(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .colr(colr), .drawing(drawing), .oe(oe),
    .shape_done(shape_done), .fb_addr(fb_addr), .fb_colr(fb_colr), .fb_we(fb_we),
    .fb_grant(fb_grant), .busy(busy), .flush_done(flush_done), .clip_cnt(clip_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset-independent drivers
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (grant_mode)
      0:       fb_grant = 1'b0;
      1:       fb_grant = 1'b1;
      2:       fb_grant = ~fb_grant;
      default: fb_grant = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: in-range pixels become writes at y*W+x, others are clipped.
  function automatic void model_accept(input int px, input int py, input int pc);
    if (px < W && py < H) exp_q.push_back({AW'(py * W + px), COLRW'(pc)});
    else if (clip_exp < 255) clip_exp++;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we && fb_grant) begin
        check("write_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          logic [AW+COLRW-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e[AW+COLRW-1:COLRW]));
          check("wr_colr", 32'(fb_colr), 32'(e[COLRW-1:0]));
        end
      end
      if (flush_done) begin
        flush_cnt++;
        check("flush_after_writes", exp_q.size(), 0);
      end
    end
  end

  task automatic offer(input int px, input int py, input int pc, input bit sd);
    int n;
    n = 0;
    x = CORDW'(px);
    y = CORDW'(py);
    colr = COLRW'(pc);
    drawing = 1'b1;
    while (!oe && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("oe_wait", 32'(n < 200), 1);
    if (oe) begin
      shape_done = sd;
      model_accept(px, py, pc);
      @(posedge clk); #1;
    end
    drawing = 1'b0;
    shape_done = 1'b0;
  endtask

  task automatic pulse_sd();
    shape_done = 1'b1;
    @(posedge clk); #1;
    shape_done = 1'b0;
  endtask

  task automatic wait_flush(input int start_cnt, input string tag);
    int n;
    n = 0;
    while (flush_cnt == start_cnt && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(tag, 32'(flush_cnt - start_cnt), 1);
  endtask

  task automatic random_shape(input int gmode, input string tag);
    int n, f;
    grant_mode = gmode;
    clip_exp = 0;
    f = flush_cnt;
    n = $urandom_range(6, 12);
    for (int i = 0; i < n; i++) begin
      offer($urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 15), i == n - 1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_flush(f, tag);
    check("rand_clip_cnt", 32'(clip_cnt), 32'(clip_exp));
  endtask

  initial begin
    int f, acc;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_oe", 32'(oe), 0);
    check("rst_clip_cnt", 32'(clip_cnt), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_flush", 32'(flush_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_oe", 32'(oe), 1);

    // basic stream, latency
    grant_mode = 1;
    clip_exp = 0;
    f = flush_cnt;
    @(posedge clk); #1;
    offer(0, 0, 5, 0);
    @(negedge clk);
    check("lat_s1_no_we", 32'(fb_we), 0);
    @(negedge clk);
    check("lat_we", 32'(fb_we), 1);
    check("lat_addr", 32'(fb_addr), 0);
    offer(1, 0, 6, 0);
    offer(0, 1, 7, 0);
    pulse_sd();
    wait_flush(f, "t1_flush_once");
    check("t1_clip_cnt", 32'(clip_cnt), 0);

    // back-pressure with grant stalled
    grant_mode = 0;
    clip_exp = 0;
    f = flush_cnt;
    @(posedge clk); #1;
    acc = 0;
    drawing = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = CORDW'(acc + 10);
      y = CORDW'(5);
      colr = COLRW'(acc);
      if (oe) begin
        model_accept(acc + 10, 5, acc);
        acc++;
      end
      @(posedge clk); #1;
    end
    drawing = 1'b0;
    check("full_accepts", acc, DEPTH);
    check("full_oe_low", 32'(oe), 0);
    check("full_head_stable", 32'(fb_addr), 5 * W + 10);
    check("full_busy", 32'(busy), 1);
    grant_mode = 1;
    for (int i = acc; i < 8; i++) offer(i + 10, 5, i, 0);
    pulse_sd();
    wait_flush(f, "t2_flush_once");

    // clipping and last-pixel address
    clip_exp = 0;
    f = flush_cnt;
    offer(W - 1, H - 1, 3, 0);
    offer(W, 0, 4, 0);
    offer(0, H, 5, 0);
    offer(1023, 1023, 6, 0);
    pulse_sd();
    wait_flush(f, "t3_flush_once");
    check("t3_clip_cnt", 32'(clip_cnt), 3);

    // shape_done with the final pixel, grant toggling, then random grant
    random_shape(2, "t4_flush_toggle");
    random_shape(3, "t4_flush_random");
    random_shape(1, "t4_flush_full_rate");

    // zero-pixel shape
    grant_mode = 1;
    @(posedge clk); #1;
    pulse_sd();
    @(negedge clk);
    check("t5_flush", 32'(flush_done), 1);
    check("t5_no_we", 32'(fb_we), 0);
    @(negedge clk);
    check("t5_flush_single", 32'(flush_done), 0);
    check("t5_idle", 32'(busy), 0);

    // reset mid-shape
    grant_mode = 0;
    @(posedge clk); #1;
    offer(2, 2, 1, 0);
    offer(3, 2, 2, 0);
    offer(4, 2, 3, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("t6_we_buffered", 32'(fb_we), 1);
    check("t6_busy_buffered", 32'(busy), 1);
    f = flush_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_rst_we", 32'(fb_we), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_oe", 32'(oe), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_mode = 1;
    #1;
    check("t6_post_oe", 32'(oe), 1);
    check("t6_no_flush", 32'(flush_cnt - f), 0);
    @(posedge clk); #1;
    clip_exp = 0;
    offer(7, 9, 9, 0);
    offer(W - 1, 0, 10, 1);
    wait_flush(f, "t6_new_shape_flush");
    check("t6_clip_cnt", 32'(clip_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
